filtr_sample_feeder: RTL and testbench
======================================

// Module: filtr_sample_feeder
// PURPOSE
//  Drives the sample side of the notch filter (filtr_a) and collects its result.
//  Accepts input samples on a valid/ready stream and issues one sample pulse with held data per sample.
//  Captures data_out on filter_done and presents each result on a downstream valid/ready stream.
//  Sits between the ADC/sample source and the output path; it is the initiator for the filter's
//  sample/filter_done handshake.
// PARAMETERS
//  DATA_SIZE  24   sample and result width, in bits (two's complement)
//  TIMEOUT    255  maximum number of cycles to wait for filter_done after a sample pulse; must be >= 1
//  CNT_W      8    width of the timeout error counter
// PORTS
//  clk          in   1          system clock, rising edge
//  reset        in   1          asynchronous, active-low reset
//  in_data      in   DATA_SIZE  input sample
//  in_valid     in   1          in_data is valid
//  in_ready     out  1          feeder can accept a sample
//  filt_data    out  DATA_SIZE  to filter data_in; held stable from the sample pulse until done or timeout
//  filt_sample  out  1          to filter sample_trig; one-cycle pulse
//  filt_result  in   DATA_SIZE  from filter data_out
//  filt_done    in   1          from filter filter_done; level or pulse, only the rising edge is used
//  out_data     out  DATA_SIZE  filtered result
//  out_valid    out  1          out_data is valid
//  out_err      out  1          qualifies out_data: this result came from a timeout (out_data = 0)
//  out_ready    in   1          downstream accepts the result
//  busy         out  1          FSM is not in IDLE
//  tmo_cnt      out  CNT_W      number of timeouts; saturates at all-ones
// BEHAVIOUR
//  Reset (reset=0, asynchronous): state=IDLE; all outputs 0 except in_ready=1; done_q=0; timer=0.
//  done_q is a registered copy of filt_done. done_rise = filt_done & ~done_q.
//  FSM states: IDLE, TRIG, WAIT, HOLD.
//   IDLE: in_ready=1. On in_valid: latch in_data into filt_data and go to TRIG.
//   TRIG: filt_sample=1 for exactly this cycle; in_ready=0; timer=0; go to WAIT.
//   WAIT: timer increments every cycle.
//    - done_rise: out_data<=filt_result, out_err<=0, out_valid<=1; go to HOLD.
//    - Otherwise, if timer==TIMEOUT-1: out_data<=0, out_err<=1, out_valid<=1; tmo_cnt+1 (saturating); go to HOLD.
//    - If both happen in the same cycle, done_rise wins.
//   HOLD: out_valid=1 while out_ready=0. out_data and out_err hold stable until accepted.
//    On out_ready: out_valid<=0, out_err<=0, go to IDLE.
//  done_rise outside WAIT is ignored: no capture, no error.
//  A done_rise in the same cycle as TRIG is ignored. The filter response is accepted from the cycle after the pulse.
//  Latency:
//   - in_valid&in_ready -> filt_sample: 1 cycle.
//   - done_rise -> out_valid: 1 cycle.
//   - Best case in -> out: 3 cycles plus the filter latency.
//  Throughput: one sample in flight at a time. in_ready stays low until the result is accepted (HOLD exit), then IDLE.
//  Back-to-back samples: the earliest next in_ready=1 is the cycle after out_ready handshake.
//  filt_data changes only when a sample is latched in IDLE.
//  Reset mid-operation: everything returns to reset values at once. A pending result is dropped and filt_sample deasserts.
//  Widths: timer has ceil(log2(TIMEOUT+1)) bits. No arithmetic on data (pass-through only).
// TESTING
//  1 Reset: hold reset=0, toggle inputs -> in_ready=1, out_valid=0, filt_sample=0, tmo_cnt=0, busy=0.
//  2 Normal: in_data=24'h123456 valid 1 cycle; model done 5 cycles after pulse with result 24'hABCDEF ->
//    filt_sample one cycle, filt_data=123456 stable, out_valid with out_data=ABCDEF, out_err=0.
//  3 Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data stay stable, in_ready=0.
//    Raise out_ready -> handshake, then in_ready=1 next cycle.
//  4 Timeout: TIMEOUT=16, no filt_done -> out_valid exactly 16 cycles after WAIT entry, out_data=0, out_err=1, tmo_cnt=1.
//    Set tmo_cnt to its maximum, then force one more timeout -> tmo_cnt stays at its maximum.
//  5 Edge cases:
//    - filt_done held high across two samples -> only the rising edge counts; the second sample times out.
//    - Stray done pulse in IDLE -> ignored.
//    - done on timer==TIMEOUT-1 -> valid result, out_err=0.
//  6 Async reset pulsed in WAIT and in HOLD, mid-cycle -> outputs are at reset values before the next clk edge.
//    A new sample after reset completes normally.

Source files
------------

// File: rtl/filtr_sample_feeder.sv
// Sample-side initiator for the notch filter: takes one sample at a time, pulses the filter,
// then returns either the captured filter result or a timeout marker on a valid/ready stream.
module filtr_sample_feeder #(
    parameter int DATA_SIZE = 24,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [DATA_SIZE-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATA_SIZE-1:0] filt_data,
    output logic                        filt_sample,
    input  logic signed [DATA_SIZE-1:0] filt_result,
    input  logic                        filt_done,
    output logic signed [DATA_SIZE-1:0] out_data,
    output logic                        out_valid,
    output logic                        out_err,
    input  logic                        out_ready,
    output logic                        busy,
    output logic        [CNT_W-1:0]     tmo_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, TRIG, WAIT, HOLD} state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             done_q;
    logic             done_rise;

    // Only the rising edge of filt_done matters, so a level-style done cannot retrigger.
    assign done_rise = filt_done & ~done_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            timer       <= '0;
            done_q      <= 1'b0;
            in_ready    <= 1'b1;
            filt_data   <= '0;
            filt_sample <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_err     <= 1'b0;
            busy        <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            done_q <= filt_done;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        filt_data   <= in_data;
                        filt_sample <= 1'b1;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= TRIG;
                    end
                end
                TRIG: begin
                    filt_sample <= 1'b0;
                    timer       <= '0;
                    state       <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // A real result arriving on the last allowed cycle beats the timeout.
                    if (done_rise) begin
                        out_data  <= filt_result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else if (timer == TMR_LAST) begin
                        out_data  <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        tmo_cnt   <= sat_inc(tmo_cnt);
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filtr_sample_feeder.sv
// Bench for filtr_sample_feeder: directed samples, expected results queued at issue time and
// checked by an independent monitor on every downstream handshake.
module tb_filtr_sample_feeder;

    logic        clk;
    logic        reset;
    logic [23:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] filt_data;
    logic        filt_sample;
    logic [23:0] filt_result;
    logic        filt_done;
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_err;
    logic        out_ready;
    logic        busy;
    logic [7:0]  tmo_cnt;

    int          total = 0;
    int          bad = 0;
    int          exp_tmo = 0;
    logic [24:0] exp_q[$];
    logic [24:0] mon_e;

    filtr_sample_feeder #(.DATA_SIZE(24), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .filt_data(filt_data), .filt_sample(filt_sample),
        .filt_result(filt_result), .filt_done(filt_done),
        .out_data(out_data), .out_valid(out_valid), .out_err(out_err), .out_ready(out_ready),
        .busy(busy), .tmo_cnt(tmo_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got data=%h err=%b, required no output", out_data, out_err);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_data", {8'h0, out_data}, {8'h0, mon_e[23:0]});
                check("result_err", {31'h0, out_err}, {31'h0, mon_e[24]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_timeout();
        if (exp_tmo < 255) exp_tmo++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("reach_idle", {31'h0, in_ready}, 32'h1);
    endtask

    task automatic send(input logic [23:0] d);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", {31'h0, in_ready}, 32'h1);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_data  = ~d;
        check("pulse_hi", {31'h0, filt_sample}, 32'h1);
        check("filt_data_latch", {8'h0, filt_data}, {8'h0, d});
        check("busy_trig", {31'h0, busy}, 32'h1);
    endtask

    // dly = cycles after the pulse edge at which filt_done rises; negative means never.
    task automatic run_sample(input logic [23:0] d, input int dly, input logic [23:0] res, input bit keep);
        send(d);
        if (dly >= 1) begin
            tick();
            check("pulse_lo", {31'h0, filt_sample}, 32'h0);
            repeat (dly - 1) tick();
        end
        if (dly >= 0) begin
            check("filt_data_held", {8'h0, filt_data}, {8'h0, d});
            filt_result = res;
            filt_done   = 1'b1;
            tick();
            if (!keep) filt_done = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; in_data = '0; in_valid = 1'b0; filt_result = '0; filt_done = 1'b0; out_ready = 1'b1;

        // Reset held low while inputs toggle
        for (int i = 0; i < 6; i++) begin
            in_valid  = i[0];
            filt_done = ~i[0];
            out_ready = i[1];
            in_data   = 24'h5A5A5A ^ 24'(i);
            tick();
        end
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_filt_sample", {31'h0, filt_sample}, 32'h0);
        check("rst_tmo_cnt", {24'h0, tmo_cnt}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        in_valid = 1'b0; filt_done = 1'b0; out_ready = 1'b1;
        #3 reset = 1'b1;
        tick();

        // Normal sample: done 5 cycles after the pulse
        exp_q.push_back({1'b0, 24'hABCDEF});
        run_sample(24'h123456, 5, 24'hABCDEF, 1'b0);

        // Backpressure: result must stay put for 10 cycles
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 24'h7FFFFF});
        send(24'h000111);
        tick();
        filt_result = 24'h7FFFFF;
        filt_done   = 1'b1;
        tick();
        filt_done   = 1'b0;
        filt_result = 24'h000000;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", {31'h0, out_valid}, 32'h1);
            check("bp_data", {8'h0, out_data}, 32'h007FFFFF);
            check("bp_in_ready", {31'h0, in_ready}, 32'h0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", {31'h0, in_ready}, 32'h1);
        check("bp_release_valid", {31'h0, out_valid}, 32'h0);

        // Timeout: out_valid exactly 16 cycles after entering WAIT
        exp_q.push_back({1'b1, 24'h000000});
        note_timeout();
        send(24'h0ABCDE);
        tick();
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("tmo_latency", 32'(n), 32'd16);
        check("tmo_err", {31'h0, out_err}, 32'h1);
        check("tmo_data", {8'h0, out_data}, 32'h0);
        check("tmo_cnt_1", {24'h0, tmo_cnt}, 32'(exp_tmo));
        wait_idle();

        // filt_done held high across two samples: second one has no rising edge
        exp_q.push_back({1'b0, 24'h654321});
        run_sample(24'h00AAAA, 3, 24'h654321, 1'b1);
        exp_q.push_back({1'b1, 24'h000000});
        note_timeout();
        run_sample(24'h00BBBB, -1, 24'h0, 1'b0);
        filt_done = 1'b0;
        check("held_done_tmo", {24'h0, tmo_cnt}, 32'(exp_tmo));

        // Stray done pulse while idle
        tick();
        filt_result = 24'h999999;
        filt_done   = 1'b1;
        tick();
        filt_done   = 1'b0;
        tick();
        tick();
        check("stray_busy", {31'h0, busy}, 32'h0);
        check("stray_valid", {31'h0, out_valid}, 32'h0);
        check("stray_tmo", {24'h0, tmo_cnt}, 32'(exp_tmo));

        // Done rising during the pulse cycle is ignored -> timeout
        exp_q.push_back({1'b1, 24'h000000});
        note_timeout();
        run_sample(24'h00CCCC, 0, 24'h111111, 1'b0);
        check("trig_done_tmo", {24'h0, tmo_cnt}, 32'(exp_tmo));

        // Earliest accepted done, and done on the final timer value
        exp_q.push_back({1'b0, 24'h000001});
        run_sample(24'h00DDDD, 1, 24'h000001, 1'b0);
        exp_q.push_back({1'b0, 24'h800001});
        run_sample(24'h00EEEE, 16, 24'h800001, 1'b0);
        check("tie_tmo_unchanged", {24'h0, tmo_cnt}, 32'(exp_tmo));

        // Async reset in WAIT
        send(24'h0F0F0F);
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_wait_in_ready", {31'h0, in_ready}, 32'h1);
        check("arst_wait_busy", {31'h0, busy}, 32'h0);
        check("arst_wait_sample", {31'h0, filt_sample}, 32'h0);
        check("arst_wait_fdata", {8'h0, filt_data}, 32'h0);
        check("arst_wait_tmo", {24'h0, tmo_cnt}, 32'h0);
        exp_tmo = 0;
        #2 reset = 1'b1;
        tick();

        // Async reset in HOLD with a pending result
        out_ready = 1'b0;
        send(24'h0E0E0E);
        tick();
        filt_result = 24'h246802;
        filt_done   = 1'b1;
        tick();
        filt_done   = 1'b0;
        check("hold_valid", {31'h0, out_valid}, 32'h1);
        #2 reset = 1'b0;
        #1;
        check("arst_hold_valid", {31'h0, out_valid}, 32'h0);
        check("arst_hold_err", {31'h0, out_err}, 32'h0);
        check("arst_hold_data", {8'h0, out_data}, 32'h0);
        check("arst_hold_in_ready", {31'h0, in_ready}, 32'h1);
        #2 reset = 1'b1;
        out_ready = 1'b1;
        tick();
        exp_q.push_back({1'b0, 24'h135790});
        run_sample(24'h0C0C0C, 3, 24'h135790, 1'b0);

        // Timeout counter saturation
        for (int i = 0; i < 255; i++) begin
            exp_q.push_back({1'b1, 24'h000000});
            note_timeout();
            run_sample(24'(i), -1, 24'h0, 1'b0);
        end
        check("tmo_cnt_max", {24'h0, tmo_cnt}, 32'd255);
        exp_q.push_back({1'b1, 24'h000000});
        note_timeout();
        run_sample(24'h0FFFFF, -1, 24'h0, 1'b0);
        check("tmo_cnt_sat", {24'h0, tmo_cnt}, 32'd255);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
